dma_fifo_rd_adapter: RTL and testbench
======================================

# dma_fifo_rd_adapter

Read-side companion of the DMA data FIFO. It drains the SRAM-backed FIFO, whose read port returns data one cycle after `rd_en`, into a valid/ready beat stream that the DMA write engine consumes. A command supplies a beat count. The block prefetches exactly that many beats through a 2-entry output buffer, marks the final beat, and pulses completion. It sits between `dma_fifo` and the DMA destination write path.

## Interface
Parameters:
- `WIDTH`, default `DMA_DATA_WIDTH` (512): beat width.
- `BEATS_W`, default 16: width of the beat-count field.

Ports:
- `clk`: input, 1 bit. Single clock.
- `srst`: input, 1 bit. Reset, synchronous and active-high.
- `clear_i`: input, 1 bit. Synchronous abort.
- `cmd_valid_i`: input, 1 bit. Burst command valid.
- `cmd_ready_o`: output, 1 bit. Command accepted; high only in IDLE.
- `cmd_beats_i`: input, `BEATS_W` bits. Number of beats to transfer.
- `fifo_empty_i`: input, 1 bit. FIFO empty flag.
- `fifo_rd_o`: output, 1 bit. FIFO read strobe.
- `fifo_data_i`: input, `WIDTH` bits. FIFO read data, valid exactly one cycle after `fifo_rd_o`.
- `m_valid_o`: output, 1 bit. Output beat valid.
- `m_ready_i`: input, 1 bit. Downstream accept.
- `m_data_o`: output, `WIDTH` bits. Output beat.
- `m_last_o`: output, 1 bit. Final beat of the burst.
- `done_o`: output, 1 bit. One-cycle pulse when the burst completes.

## Operation
- States: IDLE, RUN.
  - IDLE → RUN when `cmd_valid_i && cmd_ready_o` and `cmd_beats_i != 0`.
  - A zero-beat command is accepted, stays in IDLE, and pulses `done_o` on the next cycle. No FIFO reads and no output beats are produced.
  - RUN → IDLE on the cycle the last beat handshakes (`m_valid_o && m_ready_i && m_last_o`). `done_o` is high the following cycle.
- Counters, all `BEATS_W` bits wide:
  - `issue_left` is loaded with `cmd_beats_i` and decrements on each `fifo_rd_o`.
  - `out_left` is loaded with `cmd_beats_i` and decrements on each output handshake.
  - Neither counter underflows: `fifo_rd_o` requires `issue_left != 0`.
- `fifo_rd_o` = RUN && `!fifo_empty_i` && `issue_left != 0` && (`occ + inflight - pop) < 2`.
  - `occ` is buffer occupancy (0..2).
  - `inflight` is a 1-bit register equal to the previous cycle's `fifo_rd_o`.
  - `pop = m_valid_o && m_ready_i`.
- Returned data is written into the buffer when `inflight` is high. Push and pop in the same cycle are allowed. Occupancy never exceeds 2; the bench asserts this.
- Output side:
  - `m_valid_o = (occ != 0)`.
  - `m_data_o` is the buffer head.
  - `m_last_o = m_valid_o && (out_left == 1)`.
- `m_data_o` and `m_last_o` hold stable while `m_valid_o && !m_ready_i`.
- `clear_i` has priority over all other activity except `srst`:
  - next state is IDLE;
  - `occ`, both counters and `done_o` are zeroed;
  - `inflight` is zeroed, so a beat returning in the cycle after `clear_i` is discarded.
  - `clear_i` does not pulse `done_o`.
- `srst`: same effect as `clear_i`, plus buffer storage is zeroed.

## Timing
- Values after reset: `cmd_ready_o`=1, `fifo_rd_o`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `done_o`=0.
- Latency, with the command accepted in cycle T and the FIFO non-empty:
  - `fifo_rd_o` is first high in T+1;
  - data is captured at the end of T+2;
  - `m_valid_o` is first high in T+3.
- Throughput is 1 beat/cycle while `m_ready_i` stays high and the FIFO stays non-empty.
- Backpressure: at most 2 beats are pending (buffered plus in-flight). `fifo_rd_o` stays low until a pop frees a slot.
- `fifo_rd_o` is combinational from registered state, `fifo_empty_i` and `m_ready_i`. There is no combinational path from `fifo_data_i` to any output.
- `cmd_ready_o` is registered state only, independent of `cmd_valid_i`.

## Structure
- `dma_pkg` holds:
  - `dma_beats_t` (`logic [BEATS_W-1:0]`, with `BEATS_W`=16 as a package constant);
  - `dma_rd_state_e` enum {IDLE, RUN}.
- Sub-module `dma_rd_skid_buf`: a 2-entry register buffer with push/pop, `occ` output, head data and clear. The top level holds the FSM, the counters and the credit logic.

## Test plan
- Reset, then a 4-beat command with the FIFO pre-loaded with A0..A3 and `m_ready_i`=1:
  - `fifo_rd_o` is high in T+1..T+4;
  - beats A0..A3 appear in T+3..T+6, with `m_last_o` only on A3;
  - `done_o` is high in T+7.
- 8-beat burst with `m_ready_i` toggling 1,0,0,1,…: data order is preserved, with no duplicated or dropped beat and `occ` ≤ 2 throughout. `fifo_rd_o` count is exactly 8.
- FIFO runs empty mid-burst (empty for 5 cycles after beat 2):
  - `fifo_rd_o` is low during the empty stretch;
  - the burst resumes and ends with exactly `cmd_beats_i` beats;
  - `m_last_o` is on the final beat only.
- `clear_i` one cycle after a `fifo_rd_o`:
  - `m_valid_o`=0 and `cmd_ready_o`=1 next cycle;
  - the returning beat is discarded and `done_o` stays 0;
  - a new 2-beat command then completes normally.
- Zero-beat command: `done_o` pulses in T+1. `fifo_rd_o` and `m_valid_o` remain 0.
- Maximum count 0xFFFF beats with continuous ready: 0xFFFF handshakes, `m_last_o` exactly once, and no counter wrap.

Source files
------------

// File: rtl/dma_fifo_rd_adapter_pkg.sv
// Shared constants and types for the DMA FIFO read-side adapter.
package dma_pkg;
  localparam int DMA_DATA_WIDTH = 512;
  localparam int BEATS_W        = 16;

  typedef logic [BEATS_W-1:0] dma_beats_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dma_rd_state_e;
endpackage

// File: rtl/dma_fifo_rd_adapter_if.sv
// Command, FIFO read port and output beat stream of the read adapter.
interface dma_fifo_rd_adapter_if #(
  parameter int WIDTH   = dma_pkg::DMA_DATA_WIDTH,
  parameter int BEATS_W = dma_pkg::BEATS_W
) ();
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [BEATS_W-1:0] cmd_beats_i;
  logic               fifo_empty_i;
  logic               fifo_rd_o;
  logic [WIDTH-1:0]   fifo_data_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [WIDTH-1:0]   m_data_o;
  logic               m_last_o;
  logic               done_o;

  modport slave (
    input  cmd_valid_i, cmd_beats_i, fifo_empty_i, fifo_data_i, m_ready_i,
    output cmd_ready_o, fifo_rd_o, m_valid_o, m_data_o, m_last_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_beats_i, fifo_empty_i, fifo_data_i, m_ready_i,
    input  cmd_ready_o, fifo_rd_o, m_valid_o, m_data_o, m_last_o, done_o
  );
endinterface

// File: rtl/dma_fifo_rd_adapter_skid_buf.sv
// Two-entry register buffer holding FIFO read data until the consumer accepts it.
module dma_rd_skid_buf #(
  parameter int WIDTH = dma_pkg::DMA_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [1:0]       o_occ,
  output logic [WIDTH-1:0] o_head
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_occ;

  // Clear drops occupancy only; storage is wiped by srst alone.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];
endmodule

// File: rtl/dma_fifo_rd_adapter.sv
// Drains the one-cycle-latency DMA FIFO into a valid/ready beat stream for a
// commanded beat count, marking the last beat and pulsing completion.
module dma_fifo_rd_adapter #(
  parameter int WIDTH   = dma_pkg::DMA_DATA_WIDTH,
  parameter int BEATS_W = dma_pkg::BEATS_W
) (
  input logic                  clk,
  input logic                  srst,
  input logic                  clear_i,
  dma_fifo_rd_adapter_if.slave bus
);
  import dma_pkg::*;

  dma_rd_state_e      r_state;
  dma_rd_state_e      w_next_state;
  logic [BEATS_W-1:0] r_issue_left;
  logic [BEATS_W-1:0] r_out_left;
  logic               r_inflight;
  logic               r_done;

  logic [1:0]         w_occ;
  logic [WIDTH-1:0]   w_head;
  logic               w_valid;
  logic               w_pop;
  logic               w_accept;
  logic               w_cmd_ready;
  logic               w_fifo_rd;
  logic               w_last;
  logic [2:0]         w_pending;

  assign w_valid   = (w_occ != 2'd0);
  assign w_pop     = w_valid && bus.m_ready_i;
  assign w_accept  = (r_state == IDLE) && bus.cmd_valid_i;
  // Credit: buffered plus in-flight beats, less the one leaving this cycle.
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge clk) begin
    if (srst || clear_i) r_state <= IDLE;
    else                 r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept && (bus.cmd_beats_i != '0)) w_next_state = RUN;
      RUN:  if (w_pop && w_last)                     w_next_state = IDLE;
      default:                                       w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = (r_state == IDLE);
    w_fifo_rd   = (r_state == RUN) && !bus.fifo_empty_i &&
                  (r_issue_left != '0) && (w_pending < 3'd2);
    w_last      = w_valid && (r_out_left == BEATS_W'(1));
  end

  always_ff @(posedge clk) begin
    if (srst || clear_i) begin
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_fifo_rd;
      r_done     <= (w_accept && (bus.cmd_beats_i == '0)) ||
                    ((r_state == RUN) && w_pop && w_last);
      if (w_accept) begin
        r_issue_left <= bus.cmd_beats_i;
        r_out_left   <= bus.cmd_beats_i;
      end else if (r_state == RUN) begin
        if (w_fifo_rd) r_issue_left <= r_issue_left - BEATS_W'(1);
        if (w_pop)     r_out_left   <= r_out_left - BEATS_W'(1);
      end
    end
  end

  dma_rd_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .srst    (srst),
    .i_clear (clear_i),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (bus.fifo_data_i),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

  assign bus.cmd_ready_o = w_cmd_ready;
  assign bus.fifo_rd_o   = w_fifo_rd;
  assign bus.m_valid_o   = w_valid;
  assign bus.m_data_o    = w_head;
  assign bus.m_last_o    = w_last;
  assign bus.done_o      = r_done;
endmodule

// File: tb/tb_dma_fifo_rd_adapter.sv
// Cycle-level bench for dma_fifo_rd_adapter: queue-based reference model plus
// directed latency, backpressure, clear, zero-length and full-count bursts.
module tb_dma_fifo_rd_adapter;
  import dma_pkg::*;

  localparam int W  = DMA_DATA_WIDTH;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic srst;
  logic clear;
  always #5 clk = ~clk;

  dma_fifo_rd_adapter_if #(.WIDTH(W), .BEATS_W(BW)) bus ();

  dma_fifo_rd_adapter #(.WIDTH(W), .BEATS_W(BW)) dut (
    .clk     (clk),
    .srst    (srst),
    .clear_i (clear),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_busy;
  int          m_ileft, m_oleft;
  logic [W-1:0] m_q[$];
  bit          m_infl;
  int          m_ret_seq, m_seq;
  bit          m_done;
  // FIFO source: beat n carries word(n), handed out in read order
  int          f_seq;
  bit          f_ret_valid;
  int          f_ret_seq;
  // last observed DUT outputs
  bit          o_rd, o_valid, o_last, o_done, o_hs, o_ready;
  logic [W-1:0] o_data;
  bit          chk_en = 1'b0;

  function automatic logic [W-1:0] word(input int n);
    logic [31:0] v;
    v = 32'hA000_0000 + n[31:0];
    return {(W/32){v}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit cv, input int beats, input bit rdy, input bit clr,
                      input bit emp, input bit rst);
    logic [W-1:0] e_data;
    bit e_valid, e_last, e_rd, e_pop, nd;
    int pend;
    srst             = rst;
    clear            = clr;
    bus.cmd_valid_i  = cv;
    bus.cmd_beats_i  = beats[15:0];
    bus.m_ready_i    = rdy;
    bus.fifo_empty_i = emp;
    bus.fifo_data_i  = f_ret_valid ? word(f_ret_seq) : {(W/32){$urandom()}};
    #1;
    e_valid = (m_q.size() != 0);
    e_last  = e_valid && (m_oleft == 1);
    e_pop   = e_valid && rdy;
    pend    = m_q.size() + int'(m_infl) - int'(e_pop);
    e_rd    = m_busy && !emp && (m_ileft != 0) && (pend < 2);
    e_data  = e_valid ? m_q[0] : '0;
    if (chk_en) begin
      chk("cmd_ready", W'(bus.cmd_ready_o), W'(!m_busy));
      chk("fifo_rd",   W'(bus.fifo_rd_o),   W'(e_rd));
      chk("m_valid",   W'(bus.m_valid_o),   W'(e_valid));
      chk("m_last",    W'(bus.m_last_o),    W'(e_last));
      chk("done",      W'(bus.done_o),      W'(m_done));
      chk("occ",       W'(dut.w_occ),       W'(m_q.size()));
      chk("occ_le2",   W'(dut.w_occ > 2'd2), '0);
      if (e_valid) chk("m_data", bus.m_data_o, e_data);
    end
    o_rd    = bus.fifo_rd_o;
    o_valid = bus.m_valid_o;
    o_last  = bus.m_last_o;
    o_done  = bus.done_o;
    o_ready = bus.cmd_ready_o;
    o_data  = bus.m_data_o;
    o_hs    = bus.m_valid_o && rdy;
    nd      = 1'b0;
    if (rst || clr) begin
      m_busy = 0; m_ileft = 0; m_oleft = 0; m_q.delete(); m_infl = 0; m_done = 0;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(word(m_ret_seq));
      if (!m_busy) begin
        if (cv) begin
          if (beats == 0) nd = 1'b1;
          else begin m_busy = 1; m_ileft = beats; m_oleft = beats; end
        end
      end else begin
        if (e_rd) m_ileft--;
        if (e_pop) begin
          if (m_oleft == 1) begin nd = 1'b1; m_busy = 0; end
          m_oleft--;
        end
      end
      m_infl = e_rd;
      if (e_rd) m_ret_seq = m_seq;
      m_done = nd;
    end
    if (!rst && e_rd) m_seq++;
    f_ret_valid = bus.fifo_rd_o;
    if (bus.fifo_rd_o) begin f_ret_seq = f_seq; f_seq++; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0);
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0, 2 random; emode: 0 never empty,
  // 1 empty for 5 cycles after the second read, 2 random empty
  task automatic run_burst(input int beats, input int budget, input int rmode, input int emode,
                           output int n_rd, output int n_hs, output int n_last,
                           output bit got_done, output int n_rd_gap);
    int i, gap;
    bit emp, rdy;
    i = 0; gap = 0; n_rd = 0; n_hs = 0; n_last = 0; got_done = 0; n_rd_gap = 0;
    step(1, beats, 1, 0, 0, 0);
    while (!got_done && i < budget) begin
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (i % 3 == 0) : ($urandom_range(0, 1) == 1);
      emp = 1'b0;
      if (emode == 1 && n_rd >= 2 && gap < 5) begin emp = 1'b1; gap++; end
      else if (emode == 2) emp = ($urandom_range(0, 3) == 0);
      step(0, 0, rdy, 0, emp, 0);
      if (emode == 1 && emp && o_rd) n_rd_gap++;
      n_rd   += int'(o_rd);
      n_hs   += int'(o_hs);
      n_last += int'(o_hs && o_last);
      got_done = o_done;
      i++;
    end
  endtask

  initial begin
    bit [9:0] rdv, vv, lv, dv;
    logic [31:0] lo [10];
    logic [31:0] exp_lo [4];
    int n_rd, n_hs, n_last, n_gap, cnt;
    bit got_done;
    exp_lo = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    m_busy = 0; m_ileft = 0; m_oleft = 0; m_infl = 0; m_done = 0;
    m_seq = 0; m_ret_seq = 0; f_seq = 0; f_ret_valid = 0; f_ret_seq = 0;
    @(negedge clk);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    chk_en = 1'b1;
    #1;
    chk("rst_cmd_ready", W'(bus.cmd_ready_o), W'(1'b1));
    chk("rst_fifo_rd",   W'(bus.fifo_rd_o),   '0);
    chk("rst_m_valid",   W'(bus.m_valid_o),   '0);
    chk("rst_m_data",    bus.m_data_o,        '0);
    chk("rst_m_last",    W'(bus.m_last_o),    '0);
    chk("rst_done",      W'(bus.done_o),      '0);
    @(negedge clk);

    // 4-beat burst, latency pinned by literal cycle maps
    rdv = '0; vv = '0; lv = '0; dv = '0;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 4, 1, 0, 0, 0);
      rdv[i] = o_rd; vv[i] = o_valid; lv[i] = o_last; dv[i] = o_done;
      lo[i]  = o_data[31:0];
    end
    chk("t1_rd_cycles",    W'(rdv), W'(10'b00_0001_1110));
    chk("t1_valid_cycles", W'(vv),  W'(10'b00_0111_1000));
    chk("t1_last_cycles",  W'(lv),  W'(10'b00_0100_0000));
    chk("t1_done_cycles",  W'(dv),  W'(10'b00_1000_0000));
    for (int k = 0; k < 4; k++) chk("t1_beat_data", W'(lo[k+3]), W'(exp_lo[k]));

    // 8-beat burst under 1,0,0 backpressure
    run_burst(8, 100, 1, 0, n_rd, n_hs, n_last, got_done, n_gap);
    chk("t2_done",   W'(got_done), W'(1'b1));
    chk("t2_rd_cnt", W'(n_rd),     W'(8));
    chk("t2_hs_cnt", W'(n_hs),     W'(8));
    chk("t2_last",   W'(n_last),   W'(1));
    idle(3);

    // FIFO empty for 5 cycles after the second read
    run_burst(6, 100, 0, 1, n_rd, n_hs, n_last, got_done, n_gap);
    chk("t3_done",   W'(got_done), W'(1'b1));
    chk("t3_gap_rd", W'(n_gap),    '0);
    chk("t3_hs_cnt", W'(n_hs),     W'(6));
    chk("t3_last",   W'(n_last),   W'(1));
    idle(3);

    // clear one cycle after the first read
    step(1, 4, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("t4_rd_before_clr", W'(o_rd), W'(1'b1));
    step(0, 0, 1, 1, 0, 0);
    #1;
    chk("t4_valid_after_clr", W'(bus.m_valid_o),   '0);
    chk("t4_ready_after_clr", W'(bus.cmd_ready_o), W'(1'b1));
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      cnt += int'(o_done) + int'(o_valid);
    end
    chk("t4_no_done_no_beat", W'(cnt), '0);
    run_burst(2, 50, 0, 0, n_rd, n_hs, n_last, got_done, n_gap);
    chk("t4_done",   W'(got_done), W'(1'b1));
    chk("t4_hs_cnt", W'(n_hs),     W'(2));
    idle(2);

    // zero-beat command
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("t5_done_t1", W'(o_done), W'(1'b1));
    cnt = int'(o_rd) + int'(o_valid);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 0);
      cnt += int'(o_rd) + int'(o_valid) + int'(o_done);
    end
    chk("t5_quiet", W'(cnt), '0);

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      int b;
      b = $urandom_range(1, 24);
      run_burst(b, 400, 2, 2, n_rd, n_hs, n_last, got_done, n_gap);
      chk("t6_done",   W'(got_done), W'(1'b1));
      chk("t6_rd_cnt", W'(n_rd),     W'(b));
      chk("t6_hs_cnt", W'(n_hs),     W'(b));
      chk("t6_last",   W'(n_last),   W'(1));
      idle($urandom_range(0, 3));
    end

    // maximum beat count
    run_burst(65535, 65600, 0, 0, n_rd, n_hs, n_last, got_done, n_gap);
    chk("t7_done",   W'(got_done), W'(1'b1));
    chk("t7_hs_cnt", W'(n_hs),     W'(65535));
    chk("t7_last",   W'(n_last),   W'(1));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
